// File: rtl/serial_adder_n.sv
// Digit-serial WIDTH-bit adder (A + B + cin, DIGIT bits per cycle) with valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
`timescale 1ns/1ps
module serial_adder_n #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry_in,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             o_overflow,
`endif
    output logic             o_carry_out
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_adder_n: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic [DIGIT:0]    dsum;
    logic [WIDTH-1:0]  res_shift;
`ifdef SERIAL_ADDER_OVF_EN
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic              ovf_q, ovf_d;
`endif

    // Current digit enters at the top of the result reg, so the LSB digit ends up lowest.
    always_comb begin
        dsum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
        res_shift = (res_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    carry_d = i_carry_in;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    a_msb_d = i_a[WIDTH-1];
                    b_msb_d = i_b[WIDTH-1];
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dsum[DIGIT];
                res_d   = res_shift;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    s_d     = res_shift;
                    cout_d  = dsum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_valid     = (state_q == DONE);
    assign o_s         = s_q;
    assign o_carry_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign o_overflow  = ovf_q;
`endif

endmodule
